// File: rtl/clock_core_multi_alarm_pkg.sv
// clock_core_multi_alarm_pkg: shared FSM encoding, field selects and time limits
package clock_core_multi_alarm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } state_t;
  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
endpackage

// File: rtl/clock_core_multi_alarm_alarm_match.sv
// alarm_match: combinational table compare with lowest-index priority
module alarm_match #(
  parameter int NUM_ALARMS = 4,
  parameter int IDXW = 2
) (
  input  logic [NUM_ALARMS-1:0][4:0] tbl_hour,
  input  logic [NUM_ALARMS-1:0][5:0] tbl_min,
  input  logic [NUM_ALARMS-1:0]      tbl_en,
  input  logic [4:0]                 cur_hour,
  input  logic [5:0]                 cur_min,
  output logic                       hit,
  output logic [IDXW-1:0]            idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (tbl_en[i] && tbl_hour[i] == cur_hour && tbl_min[i] == cur_min) begin
        hit = 1'b1;
        idx = IDXW'(i);
      end
  end
endmodule

// File: rtl/clock_core_multi_alarm.sv
// clock_core_multi_alarm: HH:MM:SS clock with settable fields and a prioritised alarm table
module clock_core_multi_alarm
  import clock_core_multi_alarm_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_SEC = 60,
  localparam int IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set_en,
  input  logic [1:0]      i_set_sel,
  input  logic            i_set_inc,
  input  logic            i_alm_wr,
  input  logic [IDXW-1:0] i_alm_idx,
  input  logic [4:0]      i_alm_hour,
  input  logic [5:0]      i_alm_min,
  input  logic            i_alm_en,
  input  logic            i_ack,
  input  logic            i_snooze,
  output logic [4:0]      o_hour,
  output logic [5:0]      o_min,
  output logic [5:0]      o_sec,
  output logic            o_sec_pulse,
  output logic            o_ringing,
  output logic [IDXW-1:0] o_ring_idx,
  output logic            o_snoozing
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]               pre_cnt;
  logic                        tick, carry_s, carry_m, set_p, idx_ok, kill, hit;
  logic [5:0]                  sec_r, min_r, sec_nx, min_nx;
  logic [4:0]                  hour_r, hour_nx;
  logic [NUM_ALARMS-1:0][4:0]  tbl_hour;
  logic [NUM_ALARMS-1:0][5:0]  tbl_min;
  logic [NUM_ALARMS-1:0]       tbl_en;
  logic [IDXW-1:0]             hit_idx, ring_idx, idx_nx;
  state_t                      state, state_nx;
  logic [7:0]                  ring_cnt, rc_nx;
  logic [5:0]                  snz_cnt, sc_nx;

  assign tick    = !i_set_en && pre_cnt == PW'(TICK_DIV - 1);
  assign set_p   = i_set_en && i_set_inc;
  assign carry_s = tick && sec_r == SEC_MAX;
  assign carry_m = carry_s && min_r == MIN_MAX;
  assign idx_ok  = int'(i_alm_idx) < NUM_ALARMS;
  assign kill    = i_alm_wr && idx_ok && i_alm_idx == ring_idx && !i_alm_en;

  // set-mode increments wrap within their own field and never carry
  always_comb begin
    sec_nx  = (tick || (set_p && i_set_sel == SEL_SEC)) ? (sec_r == SEC_MAX ? 6'd0 : sec_r + 6'd1) : sec_r;
    min_nx  = (carry_s || (set_p && i_set_sel == SEL_MIN)) ? (min_r == MIN_MAX ? 6'd0 : min_r + 6'd1) : min_r;
    hour_nx = (carry_m || (set_p && i_set_sel == SEL_HOUR)) ? (hour_r == HOUR_MAX ? 5'd0 : hour_r + 5'd1) : hour_r;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre_cnt     <= '0;
      sec_r       <= '0;
      min_r       <= '0;
      hour_r      <= '0;
      o_sec_pulse <= 1'b0;
    end else begin
      pre_cnt     <= (i_set_en || tick) ? '0 : pre_cnt + PW'(1);
      sec_r       <= sec_nx;
      min_r       <= min_nx;
      hour_r      <= hour_nx;
      o_sec_pulse <= tick;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tbl_hour <= '0;
      tbl_min  <= '0;
      tbl_en   <= '0;
    end else if (i_alm_wr && idx_ok) begin
      tbl_hour[i_alm_idx] <= i_alm_hour;
      tbl_min[i_alm_idx]  <= i_alm_min;
      tbl_en[i_alm_idx]   <= i_alm_en;
    end

  // compare against the post-increment time so alarms fire at hh:mm:00
  alarm_match #(.NUM_ALARMS(NUM_ALARMS), .IDXW(IDXW)) u_match (
    .tbl_hour(tbl_hour),
    .tbl_min (tbl_min),
    .tbl_en  (tbl_en),
    .cur_hour(hour_nx),
    .cur_min (min_nx),
    .hit     (hit),
    .idx     (hit_idx)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = ring_idx;
    rc_nx    = ring_cnt;
    sc_nx    = snz_cnt;
    case (state)
      ST_IDLE:
        if (carry_s && hit) begin
          state_nx = ST_RING;
          idx_nx   = hit_idx;
          rc_nx    = '0;
        end
      ST_RING:
        if (i_ack || kill) state_nx = ST_IDLE;
        else if (i_snooze) begin
          state_nx = ST_SNOOZE;
          sc_nx    = 6'(SNOOZE_MIN);
        end else if (tick) begin
          state_nx = (ring_cnt == 8'(RING_MAX_SEC - 1)) ? ST_IDLE : ST_RING;
          rc_nx    = ring_cnt + 8'd1;
        end
      ST_SNOOZE:
        if (i_ack || kill) state_nx = ST_IDLE;
        else if (carry_s) begin
          state_nx = (snz_cnt == 6'd1) ? ST_RING : ST_SNOOZE;
          sc_nx    = snz_cnt - 6'd1;
          rc_nx    = '0;
        end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ST_IDLE;
      ring_idx   <= '0;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      o_ringing  <= 1'b0;
      o_snoozing <= 1'b0;
    end else begin
      state      <= state_nx;
      ring_idx   <= idx_nx;
      ring_cnt   <= rc_nx;
      snz_cnt    <= sc_nx;
      o_ringing  <= state_nx == ST_RING;
      o_snoozing <= state_nx == ST_SNOOZE;
    end

  assign o_hour     = hour_r;
  assign o_min      = min_r;
  assign o_sec      = sec_r;
  assign o_ring_idx = ring_idx;
endmodule

// File: tb/tb_clock_core_multi_alarm.sv
// tb_clock_core_multi_alarm: directed and random checks against a seconds-of-day reference model
module tb_clock_core_multi_alarm;
  localparam int TD = 4, NA = 5, SM = 2, RM = 3;

  logic clk = 0, rst = 0, set_en = 0, set_inc = 0, alm_wr = 0, alm_en = 0, ack = 0, snooze = 0;
  logic [1:0] set_sel = 2'd3;
  logic [2:0] alm_idx = 0, o_ring_idx;
  logic [4:0] alm_hour = 0, o_hour;
  logic [5:0] alm_min = 0, o_min, o_sec;
  logic o_sec_pulse, o_ringing, o_snoozing;

  int compared = 0, mismatched = 0;
  int m_pre, m_t, m_mode, m_idx, m_rs, m_sl;
  bit m_pulse;
  int tb_h[NA], tb_m[NA];
  bit tb_e[NA];

  clock_core_multi_alarm #(.TICK_DIV(TD), .NUM_ALARMS(NA), .SNOOZE_MIN(SM), .RING_MAX_SEC(RM)) dut (
    .clk(clk), .rst(rst), .i_set_en(set_en), .i_set_sel(set_sel), .i_set_inc(set_inc),
    .i_alm_wr(alm_wr), .i_alm_idx(alm_idx), .i_alm_hour(alm_hour), .i_alm_min(alm_min),
    .i_alm_en(alm_en), .i_ack(ack), .i_snooze(snooze), .o_hour(o_hour), .o_min(o_min),
    .o_sec(o_sec), .o_sec_pulse(o_sec_pulse), .o_ringing(o_ringing), .o_ring_idx(o_ring_idx),
    .o_snoozing(o_snoozing));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    return {9'b0, 5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), m_pulse,
            m_mode == 1, m_mode == 2, 3'(m_idx)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {9'b0, o_hour, o_min, o_sec, o_sec_pulse, o_ringing, o_snoozing, o_ring_idx};
  endfunction

  task automatic model_reset();
    m_pre = 0; m_t = 0; m_mode = 0; m_idx = 0; m_rs = 0; m_sl = 0; m_pulse = 0;
    for (int i = 0; i < NA; i++) begin tb_h[i] = 0; tb_m[i] = 0; tb_e[i] = 0; end
  endtask

  // time kept as seconds of the day; mode 0 idle, 1 ring, 2 snooze
  task automatic model_edge();
    int h, m, s, hit_i;
    bit tk, cs, kill;
    tk = 0; cs = 0; hit_i = -1;
    if (set_en) begin
      m_pre = 0;
      if (set_inc) begin
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        if (set_sel == 0) s = (s + 1) % 60;
        else if (set_sel == 1) m = (m + 1) % 60;
        else if (set_sel == 2) h = (h + 1) % 24;
        m_t = h * 3600 + m * 60 + s;
      end
    end else begin
      tk = (m_pre == TD - 1);
      m_pre = tk ? 0 : m_pre + 1;
    end
    if (tk) begin
      cs = (m_t % 60) == 59;
      m_t = (m_t + 1) % 86400;
    end
    m_pulse = tk;
    kill = alm_wr && alm_idx < NA && int'(alm_idx) == m_idx && !alm_en;
    for (int i = NA - 1; i >= 0; i--)
      if (tb_e[i] && tb_h[i] == m_t / 3600 && tb_m[i] == (m_t / 60) % 60) hit_i = i;
    if (m_mode == 0) begin
      if (cs && hit_i >= 0) begin m_mode = 1; m_idx = hit_i; m_rs = 0; end
    end else if (ack || kill) m_mode = 0;
    else if (m_mode == 1) begin
      if (snooze) begin m_mode = 2; m_sl = SM; end
      else if (tk) begin m_rs++; if (m_rs == RM) m_mode = 0; end
    end else if (cs) begin
      m_sl--;
      if (m_sl == 0) begin m_mode = 1; m_rs = 0; end
    end
    if (alm_wr && alm_idx < NA) begin
      tb_h[alm_idx] = alm_hour; tb_m[alm_idx] = alm_min; tb_e[alm_idx] = alm_en;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", dut_vec(), exp_vec());
    set_inc = 0; alm_wr = 0; ack = 0; snooze = 0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic set_time(int h, int m, int s);
    int n;
    set_en = 1;
    n = (s - m_t % 60 + 60) % 60; set_sel = 0;
    repeat (n) begin set_inc = 1; step(); end
    n = (m - (m_t / 60) % 60 + 60) % 60; set_sel = 1;
    repeat (n) begin set_inc = 1; step(); end
    n = (h - m_t / 3600 + 24) % 24; set_sel = 2;
    repeat (n) begin set_inc = 1; step(); end
    set_en = 0; set_sel = 3;
    step();
  endtask

  task automatic write_alarm(int i, int h, int m, bit e);
    alm_wr = 1; alm_idx = 3'(i); alm_hour = 5'(h); alm_min = 6'(m); alm_en = e;
    step();
  endtask

  initial begin
    int k, pulses;
    model_reset();
    #1 rst = 1;
    #2 chk("reset_state", dut_vec(), 32'd0);
    #19 rst = 0;

    set_time(23, 59, 58);
    pulses = 0;
    for (int i = 0; i < 2 * TD; i++) begin step(); pulses += int'(o_sec_pulse); end
    chk("rollover_time", dut_vec() & 32'h7FFFFF80, 32'd0);
    chk("rollover_pulses", pulses, 2);

    set_time(5, 59, 10);
    set_en = 1; set_sel = 1; set_inc = 1; step();
    chk("set_min_wrap", o_min, 0);
    chk("set_hour_hold", o_hour, 5);
    chk("set_pre_zero", dut.pre_cnt, 0);
    set_sel = 3; set_inc = 1; step();
    chk("set_sel_none", {o_hour, o_min, o_sec}, {5'd5, 6'd0, 6'd10});
    set_en = 0; set_sel = 0; set_inc = 1; step();
    chk("inc_ignored", {o_min, o_sec}, {6'd0, 6'd10});

    write_alarm(0, 7, 30, 0);
    write_alarm(1, 7, 30, 1);
    write_alarm(3, 7, 30, 1);
    set_time(7, 29, 59);
    run(TD);
    chk("prio_ringing", o_ringing, 1);
    chk("prio_idx", o_ring_idx, 1);
    chk("ring_time", {o_hour, o_min, o_sec}, {5'd7, 6'd30, 6'd0});
    run(3 * TD);
    chk("ring_timeout", {o_ringing, o_snoozing}, 2'b00);

    set_time(7, 29, 59);
    run(TD);
    chk("ring_again", o_ringing, 1);
    snooze = 1; step();
    chk("snooze_enter", {o_ringing, o_snoozing}, 2'b01);
    for (k = 0; k < 600 && !o_ringing; k++) step();
    chk("snooze_return", o_ringing, 1);
    chk("snooze_idx", o_ring_idx, 1);
    chk("snooze_len", {o_hour, o_min, o_sec}, {5'd7, 6'd32, 6'd0});
    ack = 1; snooze = 1; step();
    chk("ack_prio", {o_ringing, o_snoozing}, 2'b00);

    set_time(7, 29, 59);
    run(TD);
    snooze = 1; step();
    chk("kill_pre", o_snoozing, 1);
    write_alarm(1, 7, 30, 0);
    chk("kill_idle", {o_ringing, o_snoozing}, 2'b00);

    write_alarm(1, 7, 30, 1);
    set_time(7, 29, 59);
    run(TD);
    chk("pre_reset_ring", o_ringing, 1);
    #2 rst = 1;
    #1 chk("async_reset", dut_vec(), 32'd0);
    model_reset();
    #2 rst = 0;
    run(20);
    chk("no_refire", {o_ringing, o_snoozing}, 2'b00);
    write_alarm(0, 0, 1, 1);
    set_time(0, 0, 59);
    run(TD);
    chk("post_reset_ring", {o_ringing, o_ring_idx}, {1'b1, 3'd0});
    ack = 1; step();
    write_alarm(7, 0, 2, 1);
    set_time(0, 1, 59);
    run(TD);
    chk("bad_idx_ignored", o_ringing, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) set_en = !set_en;
      set_sel = 2'($urandom);
      set_inc = set_en ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      if ($urandom_range(39) == 0) begin
        alm_wr = 1; alm_idx = 3'($urandom);
        alm_hour = 5'(m_t / 3600);
        alm_min = 6'(((m_t / 60) + $urandom_range(1)) % 60);
        alm_en = $urandom_range(3) != 0;
      end
      ack = $urandom_range(299) == 0;
      snooze = $urandom_range(99) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
